// File: rtl/div_seq_if.sv
// div_seq_if -- request/response bundle for the sequential divider.
//   start  : request strobe, taken only while busy is low
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b   : dividend / divisor, captured when start is taken
//   busy   : operation in progress
//   done   : one-cycle pulse, result valid in that cycle
//   result : registered quotient or remainder, held until the next done
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_seq.sv
// div_seq -- restoring sequential divider, one quotient bit per cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : div_seq_if slave (start/op/a/b in, busy/done/result out)
// Fixed latency of WIDTH+1 cycles: WIDTH CALC iterations plus one FIN
// cycle for sign correction. busy is decoded from the FSM state, so it
// drops on the same edge that raises done and a start in the done cycle
// is taken immediately.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_rem_q, is_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;             // (WIDTH+1)-bit subtract plus borrow bit

    always_comb begin
        sgn     = ~bus.op[0];
        // Most-negative input negates to itself, which is exactly its
        // unsigned magnitude 2^(WIDTH-1).
        a_mag   = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag   = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = a_mag;
                    dvs_d     = b_mag;
                    // A zero divisor yields an all-ones magnitude quotient;
                    // suppressing negation keeps DIV by zero at all ones.
                    // The remainder path needs no special case: it returns a.
                    neg_quo_d = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (|bus.b);
                    neg_rem_d = sgn & bus.a[WIDTH-1];
                    is_rem_d  = bus.op[1];
                end
            end
            CALC: begin
                if (trial[WIDTH+1]) begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1))
                    state_d = FIN;
            end
            FIN: begin
                if (is_rem_q)
                    result_d = neg_rem_q ? -rem_q : rem_q;
                else
                    result_d = neg_quo_q ? -quo_q : quo_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; supported values 8, 16, 32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request; sampled on a rising edge only while busy=0.
REQ-005 Port: op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 Port: a  input  WIDTH  dividend; latched when start is accepted.
REQ-007 Port: b  input  WIDTH  divisor; latched when start is accepted.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  single-cycle pulse; result is valid in that cycle.
REQ-010 Port: result  output  WIDTH  quotient or remainder; registered, held until the next done.

Function
REQ-011 FSM states SHALL be IDLE, CALC and FIN.
- IDLE -> CALC on accepted start.
- CALC -> FIN after exactly WIDTH iterations.
- FIN -> IDLE unconditionally.
REQ-012 On acceptance, op, a and b SHALL be latched. Changes to the inputs while busy=1 SHALL have no effect.
REQ-013 For signed ops, operand magnitudes SHALL be computed at latch time. The most-negative value is taken as its unsigned magnitude 2^(WIDTH-1).
REQ-014 CALC SHALL perform one restoring-division step per cycle, MSB first:
- shift {rem, dividend} left by 1;
- trial-subtract the divisor magnitude from rem using a (WIDTH+1)-bit subtraction;
- if non-negative, keep the difference and set the quotient bit to 1; otherwise restore rem and set the quotient bit to 0.
REQ-015 FIN SHALL apply sign correction, select the output and register it into result:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-016 Latency SHALL be fixed at WIDTH+1 cycles: done is high in the cycle following the (WIDTH+1)th rising edge after the edge that accepted start.
REQ-017 busy SHALL rise on the edge that accepts start and fall on the edge that raises done. A start asserted in the done cycle SHALL therefore be accepted (back-to-back operation).
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no error indication.
REQ-019 Divide by zero (b=0), with latency unchanged:
- DIV/DIVU result = all ones;
- REM/REMU result = a.
REQ-020 Signed overflow (a = -2^(WIDTH-1), b = -1, signed op), with latency unchanged:
- DIV result = a;
- REM result = 0.
REQ-021 done SHALL be high for exactly one cycle per accepted start. result SHALL change only on the edge that raises done.

Reset
REQ-022 When rst_n=0, asynchronously and regardless of clk:
- FSM -> IDLE;
- busy=0, done=0, result=0;
- internal iteration counter and working registers cleared.
REQ-023 Reset during CALC or FIN SHALL abort the operation: no done pulse is generated for it, and the first rising edge after rst_n deasserts may accept a new start.

Verification
REQ-024 DIVU a=100, b=7, start at edge k (WIDTH=32) -> busy=1 from k; done=1 and result=14 in the cycle after edge k+33. Repeat with REMU -> result=2.
REQ-025 DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REM a=7, b=0xFFFFFFFE -> 1.
REQ-026 Special cases:
- DIVU 5/0 -> 0xFFFFFFFF;
- REM 5/0 -> 5;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
- REM with the same operands -> 0.
All at the standard 33-cycle latency.
REQ-027 Start DIVU 100/7, toggle a, b, op and start during busy -> still exactly one done with result=14. Start DIVU 9/3 in the done cycle -> accepted; next done shows 3.
REQ-028 Reset mid-operation: start DIVU 100/7, pull rst_n low at iteration 10 -> busy=0, done=0, result=0 immediately and no done afterward; release rst_n and start DIVU 9/3 -> result=3 after 33 cycles.
REQ-029 Random check: 10,000 random a/b/op vectors per WIDTH, compared against a reference model of RISC-V M-extension semantics.
